// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - store write buffer with load forwarding between MEM stage and data memory
module store_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_data,
    input  logic              cpu_we,
    input  logic              cpu_re,
    output logic [DATA_W-1:0] cpu_q,
    output logic              cpu_busy,
    output logic              empty,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_q,
    input  logic              mem_busy
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] addr_buf [DEPTH];
    logic [DATA_W-1:0] data_buf [DEPTH];
    logic [PTR_W-1:0]  head, tail;
    logic [CNT_W-1:0]  count;
    logic              hit_d;
    logic [DATA_W-1:0] fwd_q;

    logic              hit;
    logic [DATA_W-1:0] hit_data;
    logic [PTR_W-1:0]  idx;
    logic              full, do_store, do_load, load_miss, do_push, do_pop;

    // Walk oldest to youngest so the youngest matching entry overrides earlier ones.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if ((CNT_W'(i) < count) && (addr_buf[idx] == cpu_addr)) begin
                hit      = 1'b1;
                hit_data = data_buf[idx];
            end
        end
    end

    always_comb begin
        full      = (count == CNT_W'(DEPTH));
        do_store  = cpu_we && !reset;
        do_load   = cpu_re && !cpu_we && !reset;
        load_miss = do_load && !hit;
        do_push   = do_store && !full;
        do_pop    = (count != '0) && !load_miss && !mem_busy && !reset;
        mem_re    = load_miss && !mem_busy;
        mem_we    = do_pop;
        mem_addr  = mem_re ? cpu_addr : (mem_we ? addr_buf[head] : '0);
        mem_data  = mem_we ? data_buf[head] : '0;
        cpu_busy  = (do_store && full) || (load_miss && mem_busy);
        cpu_q     = hit_d ? fwd_q : mem_q;
        empty     = (count == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            hit_d <= 1'b1;
            fwd_q <= '0;
        end else begin
            if (do_push) begin
                addr_buf[tail] <= cpu_addr;
                data_buf[tail] <= cpu_data;
                tail           <= tail + 1'b1;
            end
            if (do_pop)
                head <= head + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // hit_d/fwd_q only move when a load is actually accepted.
            if (do_load && hit) begin
                hit_d <= 1'b1;
                fwd_q <= hit_data;
            end else if (mem_re) begin
                hit_d <= 1'b0;
            end
        end
    end
endmodule
